// File: rtl/frame_config_writer.sv
// Configuration frame writer: consumes a 32-bit word stream (valid/ready), parses a frame
// header, loads one data word per row onto FrameData, then pulses a single FrameStrobe bit
// for the addressed column/frame while FrameData is held stable.
//
// Optional build macro: FRAME_CHECKSUM_EN
//   When defined, each frame carries a trailing checksum word (XOR of header and all data
//   words). A mismatch raises err_chk and suppresses the strobe. When undefined, err_chk is 0.
//
// Ports:
//   CLK, RST        configuration clock, synchronous active-high reset
//   s_data/s_valid  stream word and its valid
//   s_ready         writer can accept a word (low only during the strobe cycle)
//   err_clr         clears the sticky error flags
//   FrameData       row r at [r*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe     column c, frame f at bit c*MaxFramesPerCol+f; one-hot or zero
//   busy            not idle
//   err_hdr         sticky: bad header marker
//   err_range       sticky: column or frame index out of range
//   err_chk         sticky: checksum mismatch
//   frames_written  number of strobes issued (wraps)
module frame_config_writer #(
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned NumberOfRows    = 2,
  parameter int unsigned NumberOfCols    = 4
) (
  input  logic                                      CLK,
  input  logic                                      RST,
  input  logic [FrameBitsPerRow-1:0]                s_data,
  input  logic                                      s_valid,
  output logic                                      s_ready,
  input  logic                                      err_clr,
  output logic [NumberOfRows*FrameBitsPerRow-1:0]   FrameData,
  output logic [NumberOfCols*MaxFramesPerCol-1:0]   FrameStrobe,
  output logic                                      busy,
  output logic                                      err_hdr,
  output logic                                      err_range,
  output logic                                      err_chk,
  output logic [15:0]                               frames_written
);

  localparam int unsigned StrobeW   = NumberOfCols * MaxFramesPerCol;
  localparam int unsigned DataW     = NumberOfRows * FrameBitsPerRow;
  localparam int unsigned RowW      = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam logic [7:0]  HdrMarker = 8'hFA;

  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StStrobe} state_e;

  state_e               state_q;
  logic [7:0]           col_q;
  logic [7:0]           frame_q;
  logic                 range_bad_q;
  logic [RowW-1:0]      row_q;
  logic [DataW-1:0]     data_q;
  logic [StrobeW-1:0]   strobe_q;
  logic                 err_hdr_q;
  logic                 err_range_q;
  logic [15:0]          count_q;
`ifdef FRAME_CHECKSUM_EN
  logic                 err_chk_q;
  logic [FrameBitsPerRow-1:0] chk_q;
`endif

  logic                 accept;
  logic                 last_row;
  logic                 hdr_range_bad;
  logic [31:0]          strobe_idx;
  logic [StrobeW-1:0]   strobe_onehot;

  // Only the strobe cycle refuses input, so the next header waits exactly one cycle.
  assign s_ready  = (state_q != StStrobe);
  assign accept   = s_valid & s_ready;
  assign last_row = (row_q == RowW'(NumberOfRows - 1));

  assign hdr_range_bad = (32'(s_data[23:16]) >= NumberOfCols) |
                         (32'(s_data[15:8]) >= MaxFramesPerCol);

  assign strobe_idx    = 32'(col_q) * MaxFramesPerCol + 32'(frame_q);
  assign strobe_onehot = {{(StrobeW-1){1'b0}}, 1'b1} << strobe_idx;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      col_q       <= '0;
      frame_q     <= '0;
      range_bad_q <= 1'b0;
      row_q       <= '0;
      data_q      <= '0;
      strobe_q    <= '0;
      err_hdr_q   <= 1'b0;
      err_range_q <= 1'b0;
      count_q     <= '0;
`ifdef FRAME_CHECKSUM_EN
      err_chk_q   <= 1'b0;
      chk_q       <= '0;
`endif
    end else begin
      // Strobe is a single-cycle pulse; it is only ever set on entry to StStrobe.
      strobe_q <= '0;

      // Clear first so that a coinciding error event below takes precedence.
      if (err_clr) begin
        err_hdr_q   <= 1'b0;
        err_range_q <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
        err_chk_q   <= 1'b0;
`endif
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (s_data[31:24] != HdrMarker) begin
              err_hdr_q <= 1'b1;
            end else begin
              col_q       <= s_data[23:16];
              frame_q     <= s_data[15:8];
              range_bad_q <= hdr_range_bad;
              row_q       <= '0;
`ifdef FRAME_CHECKSUM_EN
              chk_q       <= s_data;
`endif
              state_q     <= StLoad;
            end
          end
        end

        StLoad: begin
          if (accept) begin
            for (int r = 0; r < NumberOfRows; r++) begin
              if (row_q == RowW'(r)) begin
                data_q[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
              end
            end
            row_q <= row_q + 1'b1;
`ifdef FRAME_CHECKSUM_EN
            chk_q <= chk_q ^ s_data;
            if (last_row) begin
              state_q <= StCheck;
            end
`else
            if (last_row) begin
              state_q  <= StStrobe;
              strobe_q <= range_bad_q ? '0 : strobe_onehot;
            end
`endif
          end
        end

`ifdef FRAME_CHECKSUM_EN
        StCheck: begin
          if (accept) begin
            if (s_data == chk_q) begin
              state_q  <= StStrobe;
              strobe_q <= range_bad_q ? '0 : strobe_onehot;
            end else begin
              err_chk_q <= 1'b1;
              state_q   <= StIdle;
            end
          end
        end
`endif

        StStrobe: begin
          if (range_bad_q) begin
            err_range_q <= 1'b1;
          end else begin
            count_q <= count_q + 16'd1;
          end
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign FrameData      = data_q;
  assign FrameStrobe    = strobe_q;
  assign busy           = (state_q != StIdle);
  assign err_hdr        = err_hdr_q;
  assign err_range      = err_range_q;
  assign frames_written = count_q;
`ifdef FRAME_CHECKSUM_EN
  assign err_chk        = err_chk_q;
`else
  assign err_chk        = 1'b0;
`endif

endmodule

// File: tb/tb_frame_config_writer.sv
// Bench for frame_config_writer: directed frames from the test plan plus randomized frames.
// A frame-level reference model predicts each strobe (bit, data, cycle) into a scoreboard
// queue; an independent monitor pops and compares whenever FrameStrobe is non-zero.
module tb_frame_config_writer;

  localparam int FB = 32;
  localparam int MF = 20;
  localparam int NR = 2;
  localparam int NC = 4;

  logic              CLK;
  logic              RST;
  logic [FB-1:0]     s_data;
  logic              s_valid;
  logic              s_ready;
  logic              err_clr;
  logic [NR*FB-1:0]  FrameData;
  logic [NC*MF-1:0]  FrameStrobe;
  logic              busy;
  logic              err_hdr;
  logic              err_range;
  logic              err_chk;
  logic [15:0]       frames_written;

  frame_config_writer #(
    .FrameBitsPerRow(FB),
    .MaxFramesPerCol(MF),
    .NumberOfRows   (NR),
    .NumberOfCols   (NC)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .err_clr       (err_clr),
    .FrameData     (FrameData),
    .FrameStrobe   (FrameStrobe),
    .busy          (busy),
    .err_hdr       (err_hdr),
    .err_range     (err_range),
    .err_chk       (err_chk),
    .frames_written(frames_written)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_err = 0;

  // Reference model state
  logic [15:0]     m_count;
  logic [NR*FB-1:0] m_fd;
  logic            m_err_hdr, m_err_range, m_err_chk;
  bit              prev_strobe;
  logic [FB-1:0]   fr_dat [NR];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every non-zero strobe must match the oldest prediction.
  always @(negedge CLK) begin
    exp_t e;
    if (FrameStrobe !== '0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_strobe: got %0h expected 0", FrameStrobe);
      end else begin
        e = sb.pop_front();
        check("strobe_vec", 128'(FrameStrobe), 128'(1) << e.idx);
        check("strobe_data", 128'(FrameData), 128'(e.data));
        check("strobe_cycle", 128'(cyc), 128'(e.cyc));
        check("ready_in_strobe", 128'(s_ready), 128'(0));
        check("busy_in_strobe", 128'(busy), 128'(1));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
    prev_strobe = 0;
  endtask

  task automatic send_word(input logic [FB-1:0] w, input int gap, input int exp_stall);
    int   stalls;
    logic rdy;
    stalls = 0;
    repeat (gap) begin
      @(posedge CLK);
      #1;
    end
    s_data  = w;
    s_valid = 1'b1;
    forever begin
      @(negedge CLK);
      rdy = s_ready;
      @(posedge CLK);
      #1;
      if (rdy) break;
      stalls++;
      if (stalls > 8) begin
        $display("FAIL send_timeout: got no ready after %0d cycles expected ready", stalls);
        break;
      end
    end
    s_valid = 1'b0;
    s_data  = $urandom;
    check("stall_count", 128'(stalls), 128'(exp_stall));
  endtask

  // Sends one frame from hdr and fr_dat[], predicting its outcome at frame level.
  task automatic send_frame(input logic [FB-1:0] hdr, input bit bad_chk,
                            input int min_gap, input int max_gap);
    int            gap, col, frm;
    bit            in_range, strobe;
    logic [FB-1:0] chk;
    exp_t          e;
    gap = $urandom_range(max_gap, min_gap);
    send_word(hdr, gap, (prev_strobe && gap == 0) ? 1 : 0);
    if (hdr[31:24] != 8'hFA) begin
      m_err_hdr   = 1'b1;
      prev_strobe = 0;
      return;
    end
    col      = int'(hdr[23:16]);
    frm      = int'(hdr[15:8]);
    in_range = (col < NC) && (frm < MF);
    chk      = hdr;
    for (int r = 0; r < NR; r++) begin
      send_word(fr_dat[r], $urandom_range(max_gap, min_gap), 0);
      m_fd[r*FB +: FB] = fr_dat[r];
      chk ^= fr_dat[r];
    end
    strobe = 1;
`ifdef FRAME_CHECKSUM_EN
    send_word(bad_chk ? ~chk : chk, $urandom_range(max_gap, min_gap), 0);
    if (bad_chk) begin
      strobe    = 0;
      m_err_chk = 1'b1;
    end
`endif
    prev_strobe = strobe;
    if (strobe) begin
      if (in_range) begin
        e.idx  = col * MF + frm;
        e.data = m_fd;
        e.cyc  = cyc;
        sb.push_back(e);
        m_count = m_count + 16'd1;
      end else begin
        m_err_range = 1'b1;
      end
    end
  endtask

  task automatic check_status(input string tag);
    wait_cycles(3);
    $display("status check: %s", tag);
    check("frames_written", 128'(frames_written), 128'(m_count));
    check("err_hdr", 128'(err_hdr), 128'(m_err_hdr));
    check("err_range", 128'(err_range), 128'(m_err_range));
    check("err_chk", 128'(err_chk), 128'(m_err_chk));
    check("frame_data", 128'(FrameData), 128'(m_fd));
    check("pending_strobes", 128'(sb.size()), 128'(0));
    check("busy_idle", 128'(busy), 128'(0));
  endtask

  task automatic check_reset_vals();
    check("rst_frame_data", 128'(FrameData), 128'(0));
    check("rst_strobe", 128'(FrameStrobe), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_errs", 128'({err_hdr, err_range, err_chk}), 128'(0));
    check("rst_count", 128'(frames_written), 128'(0));
    check("rst_ready", 128'(s_ready), 128'(1));
  endtask

  task automatic model_reset();
    m_count     = '0;
    m_fd        = '0;
    m_err_hdr   = 1'b0;
    m_err_range = 1'b0;
    m_err_chk   = 1'b0;
    prev_strobe = 0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(posedge CLK);
    #1;
    err_clr     = 1'b0;
    m_err_hdr   = 1'b0;
    m_err_range = 1'b0;
    m_err_chk   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mk;
    RST     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    err_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    check_reset_vals();

    // Good frame, no gaps: strobe bit 23 one cycle after the last data word.
    fr_dat[0] = 32'hDEADBEEF;
    fr_dat[1] = 32'h12345678;
    send_frame(32'hFA010300, 0, 0, 0);
    check_status("good frame");

    // Bad marker coinciding with err_clr: the error must win. Then a good frame.
    err_clr = 1'b1;
    send_frame(32'hAB000000, 0, 0, 0);
    err_clr = 1'b0;
    fr_dat[0] = 32'h0BADF00D;
    fr_dat[1] = 32'hCAFEF00D;
    send_frame(32'hFA020500, 0, 0, 0);
    check_status("bad marker");
    pulse_err_clr();
    check_status("err_clr");

    // Out-of-range column and frame: data consumed, no strobe.
    fr_dat[0] = 32'h11111111;
    fr_dat[1] = 32'h22222222;
    send_frame(32'hFA040000, 0, 0, 0);
    fr_dat[0] = 32'h33333333;
    fr_dat[1] = 32'h44444444;
    send_frame(32'hFA001400, 0, 0, 0);
    check_status("out of range");
    pulse_err_clr();

    // Gapped stream, followed back-to-back by another frame (header stalls in strobe cycle).
    fr_dat[0] = 32'hA5A5A5A5;
    fr_dat[1] = 32'h5A5A5A5A;
    send_frame(32'hFA031300, 0, 1, 1);
    fr_dat[0] = 32'h01020304;
    fr_dat[1] = 32'h05060708;
    send_frame(32'hFA000200, 0, 0, 0);
    check_status("gaps");

`ifdef FRAME_CHECKSUM_EN
    fr_dat[0] = 32'h1;
    fr_dat[1] = 32'h2;
    send_frame(32'hFA000100, 0, 0, 0);
    send_frame(32'hFA000100, 1, 0, 0);
    check_status("checksum");
    pulse_err_clr();
`endif

    // Reset mid-frame: header plus one data word, then RST.
    wait_cycles(2);
    send_word(32'hFA000000, 0, 0);
    send_word(32'hFFFF0000, 0, 0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    check_reset_vals();
    fr_dat[0] = 32'hC0FFEE00;
    fr_dat[1] = 32'h00C0FFEE;
    send_frame(32'hFA000000, 0, 0, 0);
    check_status("after reset");

    // Randomized frames.
    for (int i = 0; i < 150; i++) begin
      mk = ($urandom_range(7) == 0) ? 8'(8'hA0 + $urandom_range(15)) : 8'hFA;
      for (int r = 0; r < NR; r++) fr_dat[r] = $urandom;
      send_frame({mk, 8'($urandom_range(5)), 8'($urandom_range(22)), 8'($urandom)},
                 ($urandom_range(3) == 0), 0, 2);
      if (i % 25 == 24) begin
        check_status("random batch");
        pulse_err_clr();
        check("err_cleared", 128'({err_hdr, err_range, err_chk}), 128'(0));
      end
    end
    check_status("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
